spi_burst_controller: RTL and testbench

SPI_BURST_CONTROLLER -- requirements
Module: spi_burst_controller

---
 rtl/spi_burst_pkg.sv | 37 +++
 rtl/spi_burst_regfile.sv | 73 +++++++
 rtl/spi_burst_controller.sv | 187 ++++++++++++++++++
 tb/tb_spi_burst_controller.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_burst_pkg.sv
// Shared constants for the SPI burst controller: opcodes, address areas,
// control-register indices, FSM states and the pointer-advance helper.
package spi_burst_pkg;

  localparam logic [7:0] OP_READ    = 8'h03;
  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_ENABLE  = 8'h80;
  localparam logic [7:0] OP_STREAM  = 8'h81;
  localparam logic [7:0] OP_DISABLE = 8'h82;

  localparam logic [1:0] AREA_CTRL   = 2'b00;
  localparam logic [1:0] AREA_CHAR   = 2'b01;
  localparam logic [1:0] AREA_MASK   = 2'b10;
  localparam logic [1:0] AREA_RESULT = 2'b11;

  localparam logic [5:0] CTRL_WORD_SIZE   = 6'd0;
  localparam logic [5:0] CTRL_RESULT_MASK = 6'd1;
  localparam logic [5:0] CTRL_STATUS      = 6'd2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_DATA = 3'd4,
    ST_LEN  = 3'd5,
    ST_DATA = 3'd6
  } state_t;

  // Advance the index inside its area; control wraps at 4, lane areas at lanes.
  function automatic logic [7:0] ptr_next(input logic [7:0] ptr, input int unsigned lanes);
    logic [5:0] wrap_mask;
    wrap_mask = (ptr[7:6] == AREA_CTRL) ? 6'd3 : 6'(lanes - 32'd1);
    return {ptr[7:6], (ptr[5:0] + 6'd1) & wrap_mask};
  endfunction

endpackage

// File: rtl/spi_burst_regfile.sv
// Character/mask lane storage plus the indexed read mux over the
// character, mask and read-only result lanes.
module spi_burst_regfile
  import spi_burst_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int IDX_W     = $clog2(NUM_LANES)
) (
  input  logic                   sclk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [7:0]             wr_addr,
  input  logic [7:0]             wr_data,
  input  logic [7:0]             rd_addr,
  input  logic [8*NUM_LANES-1:0] result_ids,
  output logic [7:0]             rd_data,
  output logic [8*NUM_LANES-1:0] characters,
  output logic [8*NUM_LANES-1:0] masks
);

  logic [7:0]       char_r [NUM_LANES];
  logic [7:0]       mask_r [NUM_LANES];
  logic             wr_in_range_s;
  logic             rd_in_range_s;
  logic [IDX_W-1:0] wr_lane_s;
  logic [IDX_W-1:0] rd_lane_s;

  assign wr_in_range_s = wr_addr[5:0] < 6'(NUM_LANES);
  assign rd_in_range_s = rd_addr[5:0] < 6'(NUM_LANES);
  assign wr_lane_s     = wr_addr[IDX_W-1:0];
  assign rd_lane_s     = rd_addr[IDX_W-1:0];

  // Lane storage; out-of-range indices and the result area never write.
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        char_r[i] <= 8'h00;
        mask_r[i] <= 8'h00;
      end
    end else if (we && wr_in_range_s) begin
      if (wr_addr[7:6] == AREA_CHAR) begin
        char_r[wr_lane_s] <= wr_data;
      end else if (wr_addr[7:6] == AREA_MASK) begin
        mask_r[wr_lane_s] <= wr_data;
      end else begin
        char_r[wr_lane_s] <= char_r[wr_lane_s];
      end
    end else begin
      char_r[0] <= char_r[0];
    end
  end

  // Indexed lane read; anything outside the lane range reads as zero.
  always_comb begin
    rd_data = 8'h00;
    if (rd_in_range_s) begin
      case (rd_addr[7:6])
        AREA_CHAR:   rd_data = char_r[rd_lane_s];
        AREA_MASK:   rd_data = mask_r[rd_lane_s];
        AREA_RESULT: rd_data = result_ids[{rd_lane_s, 3'b000} +: 8];
        default:     rd_data = 8'h00;
      endcase
    end else begin
      rd_data = 8'h00;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane_out
    assign characters[8*g +: 8] = char_r[g];
    assign masks[8*g +: 8]      = mask_r[g];
  end

endmodule

// File: rtl/spi_burst_controller.sv
// Byte-wide SPI-style command decoder: burst register read/write over
// control and lane areas, plus a length-prefixed AXI-Stream byte emitter.
module spi_burst_controller
  import spi_burst_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int IDX_W     = $clog2(NUM_LANES)
) (
  input  logic                   sclk,
  input  logic                   rst_n,
  input  logic                   cs,
  input  logic [7:0]             mosi,
  output logic [7:0]             miso,
  output logic [7:0]             word_size,
  output logic [7:0]             result_mask,
  output logic [8*NUM_LANES-1:0] characters,
  output logic [8*NUM_LANES-1:0] masks,
  input  logic [8*NUM_LANES-1:0] result_ids,
  output logic                   aclk,
  output logic                   aresetn,
  output logic                   m_axis_tvalid,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready
);

  state_t     state_r, state_s;
  logic [7:0] ptr_r, cnt_r, miso_r, word_size_r, result_mask_r, tdata_r;
  logic       aresetn_r, overflow_r, tvalid_r, tuser_r, tlast_r;
  logic [7:0] ptr_nxt_s, rd_addr_s, lane_rd_s, rd_data_s;
  logic       wr_en_s, clear_ovf_s;

  assign ptr_nxt_s   = ptr_next(ptr_r, NUM_LANES);
  assign rd_addr_s   = (state_r == RD_ADDR) ? mosi : ptr_nxt_s;
  assign wr_en_s     = !cs && (state_r == WR_DATA);
  assign clear_ovf_s = wr_en_s && (ptr_r == {AREA_CTRL, CTRL_STATUS}) && mosi[0];

  spi_burst_regfile #(
    .NUM_LANES(NUM_LANES),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .we        (wr_en_s),
    .wr_addr   (ptr_r),
    .wr_data   (mosi),
    .rd_addr   (rd_addr_s),
    .result_ids(result_ids),
    .rd_data   (lane_rd_s),
    .characters(characters),
    .masks     (masks)
  );

  // Read mux: control area lives here, lane areas come from the regfile.
  always_comb begin
    rd_data_s = 8'h00;
    if (rd_addr_s[7:6] == AREA_CTRL) begin
      case (rd_addr_s[5:0])
        CTRL_WORD_SIZE:   rd_data_s = word_size_r;
        CTRL_RESULT_MASK: rd_data_s = result_mask_r;
        CTRL_STATUS:      rd_data_s = {6'b000000, aresetn_r, overflow_r};
        default:          rd_data_s = 8'h00;
      endcase
    end else begin
      rd_data_s = lane_rd_s;
    end
  end

  // FSM state register.
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state; deselect always returns to IDLE.
  always_comb begin
    state_s = state_r;
    if (cs) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          case (mosi)
            OP_READ:   state_s = RD_ADDR;
            OP_WRITE:  state_s = WR_ADDR;
            OP_STREAM: state_s = ST_LEN;
            default:   state_s = IDLE;
          endcase
        end
        RD_ADDR: state_s = RD_DATA;
        RD_DATA: state_s = RD_DATA;
        WR_ADDR: state_s = WR_DATA;
        WR_DATA: state_s = WR_DATA;
        ST_LEN:  state_s = (mosi == 8'h00) ? IDLE : ST_DATA;
        ST_DATA: state_s = (cnt_r == 8'd1) ? IDLE : ST_DATA;
        default: state_s = IDLE;
      endcase
    end
  end

  // Datapath: pointer/count, control registers, read data and stream beats.
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      ptr_r         <= 8'h00;
      cnt_r         <= 8'h00;
      miso_r        <= 8'h00;
      word_size_r   <= 8'h00;
      result_mask_r <= 8'h00;
      aresetn_r     <= 1'b0;
      overflow_r    <= 1'b0;
      tvalid_r      <= 1'b0;
      tdata_r       <= 8'h00;
      tuser_r       <= 1'b0;
      tlast_r       <= 1'b0;
    end else begin
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
      // Set takes precedence over a same-cycle clear.
      if (tvalid_r && !m_axis_tready) begin
        overflow_r <= 1'b1;
      end else if (clear_ovf_s) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (cs) begin
        ptr_r <= 8'h00;
        cnt_r <= 8'h00;
      end else begin
        case (state_r)
          IDLE: begin
            if (mosi == OP_ENABLE) begin
              aresetn_r <= 1'b1;
            end else if (mosi == OP_DISABLE) begin
              aresetn_r <= 1'b0;
            end else begin
              aresetn_r <= aresetn_r;
            end
          end
          RD_ADDR: begin
            ptr_r  <= mosi;
            miso_r <= rd_data_s;
          end
          RD_DATA: begin
            ptr_r  <= rd_addr_s;
            miso_r <= rd_data_s;
          end
          WR_ADDR: ptr_r <= mosi;
          WR_DATA: begin
            ptr_r <= ptr_nxt_s;
            if (ptr_r == {AREA_CTRL, CTRL_WORD_SIZE}) begin
              word_size_r <= mosi;
            end else if (ptr_r == {AREA_CTRL, CTRL_RESULT_MASK}) begin
              result_mask_r <= mosi;
            end else begin
              word_size_r <= word_size_r;
            end
          end
          ST_LEN: cnt_r <= mosi;
          ST_DATA: begin
            tdata_r  <= mosi;
            tvalid_r <= 1'b1;
            tuser_r  <= (mosi == 8'h00);
            tlast_r  <= (cnt_r == 8'd1);
            cnt_r    <= cnt_r - 8'd1;
          end
          default: ptr_r <= 8'h00;
        endcase
      end
    end
  end

  assign aclk          = sclk;
  assign miso          = miso_r;
  assign word_size     = word_size_r;
  assign result_mask   = result_mask_r;
  assign aresetn       = aresetn_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tdata  = tdata_r;
  assign m_axis_tuser  = tuser_r;
  assign m_axis_tlast  = tlast_r;

endmodule

// File: tb/tb_spi_burst_controller.sv
// Scoreboard bench: transaction tasks drive bytes and queue expected miso
// values and AXIS beats from a register-array model; a monitor compares them.
module tb_spi_burst_controller;

  localparam int N = 8;

  logic           sclk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cs = 1'b1;
  logic [7:0]     mosi = 8'h00;
  logic           m_axis_tready = 1'b1;
  logic [8*N-1:0] result_ids = '0;
  logic [7:0]     miso, word_size, result_mask, m_axis_tdata;
  logic [8*N-1:0] characters, masks;
  logic           aclk, aresetn, m_axis_tvalid, m_axis_tuser, m_axis_tlast;

  spi_burst_controller #(.NUM_LANES(N)) dut (
    .sclk(sclk), .rst_n(rst_n), .cs(cs), .mosi(mosi), .miso(miso),
    .word_size(word_size), .result_mask(result_mask),
    .characters(characters), .masks(masks), .result_ids(result_ids),
    .aclk(aclk), .aresetn(aresetn),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready)
  );

  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc++;

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic [7:0] m_char [N];
  logic [7:0] m_mask [N];
  logic [7:0] m_ws = 8'h00, m_rm = 8'h00;
  bit         m_en = 1'b0, m_ovf = 1'b0, beat_last = 1'b0;
  logic [7:0] data_q [$];

  typedef struct { int tag; logic [7:0] val; } miso_exp_t;
  typedef struct { logic [7:0] data; logic user; logic last; } beat_t;
  miso_exp_t miso_q [$];
  beat_t     beat_q [$];
  miso_exp_t me;
  beat_t     be;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: miso at the cycle its read edge completed, AXIS on every valid beat
  always @(negedge sclk) begin
    while (miso_q.size() > 0 && miso_q[0].tag <= cyc) begin
      me = miso_q.pop_front();
      check("miso", {56'h0, miso}, {56'h0, me.val});
    end
    if (m_axis_tvalid === 1'b1) begin
      if (beat_q.size() == 0) begin
        checks++;
        $display("FAIL axis_beat: got unexpected beat %0h expected none", m_axis_tdata);
      end else begin
        be = beat_q.pop_front();
        check("axis_beat", {54'h0, m_axis_tdata, m_axis_tuser, m_axis_tlast},
              {54'h0, be.data, be.user, be.last});
      end
    end
  end

  function automatic logic [7:0] m_reg(input logic [1:0] area, input int idx);
    case (area)
      2'd0: begin
        if (idx == 0) return m_ws;
        if (idx == 1) return m_rm;
        if (idx == 2) return {6'b0, m_en, m_ovf};
        return 8'h00;
      end
      2'd1: return (idx < N) ? m_char[idx] : 8'h00;
      2'd2: return (idx < N) ? m_mask[idx] : 8'h00;
      default: return (idx < N) ? result_ids[8*idx +: 8] : 8'h00;
    endcase
  endfunction

  // k-th index of a burst starting at start, wrapping inside its area
  function automatic int m_idx(input int start, input int k, input logic [1:0] area);
    int md;
    md = (area == 2'd0) ? 4 : N;
    return (k == 0) ? start : (start + k) % md;
  endfunction

  // stall: -2 random readiness, -1 always ready, else sink stalls on that beat
  function automatic bit pick_rdy(input int pos, input int stall);
    if (stall == -2) return ($urandom_range(0, 9) != 0);
    return (pos - 1 != stall);
  endfunction

  function automatic logic [7:0] next_data();
    if (data_q.size() > 0) return data_q.pop_front();
    return 8'($urandom);
  endfunction

  // One byte cycle; the sink-not-ready rule is applied to the beat of the previous cycle
  task automatic drive(input bit c, input logic [7:0] b, input bit rdy, input bit beat);
    @(negedge sclk);
    cs = c; mosi = b; m_axis_tready = rdy;
    if (beat_last && !rdy) m_ovf = 1'b1;
    beat_last = beat;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 8'($urandom), pick_rdy(0, -2), 1'b0);
  endtask

  task automatic do_op(input logic [7:0] op);
    drive(1'b0, op, 1'b1, 1'b0);
    if (op == 8'h80) m_en = 1'b1;
    if (op == 8'h82) m_en = 1'b0;
    idle(1);
  endtask

  task automatic do_write(input logic [7:0] addr, input int n);
    logic [7:0] b;
    int idx;
    drive(1'b0, 8'h02, 1'b1, 1'b0);
    drive(1'b0, addr, 1'b1, 1'b0);
    for (int k = 0; k < n; k++) begin
      b = next_data();
      idx = m_idx(int'(addr[5:0]), k, addr[7:6]);
      case (addr[7:6])
        2'd0: begin
          if (idx == 0) m_ws = b;
          if (idx == 1) m_rm = b;
          if (idx == 2 && b[0]) m_ovf = 1'b0;
        end
        2'd1: if (idx < N) m_char[idx] = b;
        2'd2: if (idx < N) m_mask[idx] = b;
        default: ;
      endcase
      drive(1'b0, b, 1'b1, 1'b0);
    end
    idle(1);
  endtask

  task automatic do_read(input logic [7:0] addr, input int n);
    logic [7:0] e;
    drive(1'b0, 8'h03, 1'b1, 1'b0);
    for (int k = 0; k < n; k++) begin
      e = m_reg(addr[7:6], m_idx(int'(addr[5:0]), k, addr[7:6]));
      drive(1'b0, (k == 0) ? addr : 8'($urandom), 1'b1, 1'b0);
      miso_q.push_back('{cyc + 1, e});
    end
    idle(1);
  endtask

  task automatic do_stream(input int len, input int nsent, input int stall);
    logic [7:0] b;
    drive(1'b0, 8'h81, pick_rdy(-5, stall), 1'b0);
    drive(1'b0, 8'(len), pick_rdy(-5, stall), 1'b0);
    for (int j = 0; j < nsent; j++) begin
      b = next_data();
      beat_q.push_back('{b, b == 8'h00, j == len - 1});
      drive(1'b0, b, pick_rdy(j, stall), 1'b1);
    end
    drive(1'b1, 8'($urandom), pick_rdy(nsent, stall), 1'b0);
  endtask

  task automatic check_all(input string tag);
    logic [8*N-1:0] pc, pm;
    for (int i = 0; i < N; i++) begin
      pc[8*i +: 8] = m_char[i];
      pm[8*i +: 8] = m_mask[i];
    end
    check({tag, " word_size"}, 64'(word_size), 64'(m_ws));
    check({tag, " result_mask"}, 64'(result_mask), 64'(m_rm));
    check({tag, " characters"}, 64'(characters), 64'(pc));
    check({tag, " masks"}, 64'(masks), 64'(pm));
    check({tag, " aresetn"}, 64'(aresetn), 64'(m_en));
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_char[i] = 8'h00;
      m_mask[i] = 8'h00;
    end
    m_ws = 8'h00; m_rm = 8'h00; m_en = 1'b0; m_ovf = 1'b0; beat_last = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_all(tag);
    check({tag, " miso"}, 64'(miso), 64'h0);
    check({tag, " axis"}, {53'h0, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}, 64'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int kind;
    logic [7:0] a;
    int len;
    model_reset();
    for (int i = 0; i < N; i++) result_ids[8*i +: 8] = 8'($urandom);
    repeat (3) @(negedge sclk);
    rst_n = 1'b1;
    check_zero_outputs("reset");

    // Burst write into character lanes 0 and 1
    data_q.push_back(8'hAA); data_q.push_back(8'hBB);
    do_write(8'h40, 2);
    check_all("burst_write");

    // Preload masks, then read 7 -> 0 -> 1 across the lane wrap
    do_write(8'h80, N);
    do_read(8'h87, 3);
    do_read(8'hC0, N + 2);

    // Enable, three-beat stream with a zero byte in the middle
    do_op(8'h80);
    data_q.push_back(8'h11); data_q.push_back(8'h00); data_q.push_back(8'h22);
    do_stream(3, 3, -1);
    check_all("stream");

    // Sink stalls on beat 2 -> overflow; then clear it through status
    data_q.push_back(8'h11); data_q.push_back(8'h00); data_q.push_back(8'h22);
    do_stream(3, 3, 1);
    do_read(8'h02, 1);
    data_q.push_back(8'h01);
    do_write(8'h02, 1);
    do_read(8'h02, 1);

    // Stream aborted after 2 of 5 beats; next read still decodes
    do_write(8'h01, 1);
    do_stream(5, 2, -1);
    do_read(8'h01, 1);
    do_stream(0, 0, -1);

    // Control-area wrap and out-of-range lane indices
    do_write(8'h00, 6);
    do_read(8'h03, 6);
    do_write(8'h4E, 3);
    do_read(8'hCA, 2);
    check_all("wrap_ctrl");

    // Random transactions
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 3);
      a = 8'({$urandom_range(0, 3), 6'($urandom_range(0, 15))});
      if (t % 10 == 0)
        for (int i = 0; i < N; i++) result_ids[8*i +: 8] = 8'($urandom);
      case (kind)
        0: do_op(($urandom_range(0, 1) != 0) ? 8'($urandom_range(8'h80, 8'h82)) : 8'($urandom));
        1: do_write(a, $urandom_range(1, 10));
        2: do_read(a, $urandom_range(1, 10));
        default: begin
          len = $urandom_range(0, 6);
          do_stream(len, (len == 0) ? 0 : $urandom_range(0, len), -2);
        end
      endcase
      check_all("random");
    end
    do_read(8'h02, 1);

    // Reset in the middle of a write burst, then ENABLE as the next byte
    drive(1'b0, 8'h02, 1'b1, 1'b0);
    drive(1'b0, 8'h40, 1'b1, 1'b0);
    drive(1'b0, 8'hAA, 1'b1, 1'b0);
    @(negedge sclk);
    rst_n = 1'b0;
    mosi = 8'h55;
    @(negedge sclk);
    rst_n = 1'b1;
    model_reset();
    check_zero_outputs("reset_mid_write");
    drive(1'b0, 8'h80, 1'b1, 1'b0);
    m_en = 1'b1;
    idle(2);
    check_all("enable_after_reset");

    checks++;
    if (miso_q.size() == 0 && beat_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d miso and %0d beats pending expected 0 and 0",
                  miso_q.size(), beat_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
